// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: piece types, board geometry, generator states and
// spawn-mask helper used by the generation, movement and landing stages.
package tetris_pkg;

  localparam int unsigned BOARD_W = 10;
  localparam int unsigned BOARD_H = 20;

  localparam logic [2:0] PIECE_I = 3'd0;
  localparam logic [2:0] PIECE_O = 3'd1;
  localparam logic [2:0] PIECE_T = 3'd2;
  localparam logic [2:0] PIECE_S = 3'd3;
  localparam logic [2:0] PIECE_Z = 3'd4;
  localparam logic [2:0] PIECE_J = 3'd5;
  localparam logic [2:0] PIECE_L = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StPick,
    StRd0,
    StRd1,
    StCheck,
    StDone
  } gen_state_e;

  typedef struct packed {
    logic [BOARD_W-1:0] m0;
    logic [BOARD_W-1:0] m1;
  } spawn_mask_t;

  // Occupancy of the top two rows for rotation 0, bounding box starting at column x.
  function automatic spawn_mask_t spawn_mask(input logic [2:0] ptype, input logic [3:0] x);
    logic [3:0]  b0;
    logic [3:0]  b1;
    spawn_mask_t m;
    b0 = 4'b0000;
    b1 = 4'b0000;
    case (ptype)
      PIECE_I: begin b0 = 4'b0000; b1 = 4'b1111; end
      PIECE_O: begin b0 = 4'b0110; b1 = 4'b0110; end
      PIECE_T: begin b0 = 4'b0010; b1 = 4'b0111; end
      PIECE_S: begin b0 = 4'b0110; b1 = 4'b0011; end
      PIECE_Z: begin b0 = 4'b0011; b1 = 4'b0110; end
      PIECE_J: begin b0 = 4'b0001; b1 = 4'b0111; end
      PIECE_L: begin b0 = 4'b0100; b1 = 4'b0111; end
      default: ;
    endcase
    m.m0 = {{(BOARD_W-4){1'b0}}, b0} << x;
    m.m1 = {{(BOARD_W-4){1'b0}}, b1} << x;
    return m;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances only while enabled.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clka,
  input  logic        restart_n,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] state_q;

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= SEED;
    end else if (en) begin
      state_q <= {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
    end
  end

  assign state = state_q;

endmodule

// File: rtl/piece_gen.sv
// Piece generation stage: draws the next tetromino from a 7-bag, reads the top two
// board rows and reports completion and spawn collision to the game FSM.
module piece_gen
  import tetris_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned MAX_TRIES = 16,
  parameter int unsigned SPAWN_X   = 3
) (
  input  logic                clka,
  input  logic                restart_n,
  input  logic                restart,
  input  logic                start_gen,
  output logic                brd_rd_en,
  output logic [4:0]          brd_rd_addr,
  input  logic [BOARD_W-1:0]  brd_rd_data,
  output logic [2:0]          piece_type,
  output logic [3:0]          piece_x,
  output logic [4:0]          piece_y,
  output logic [1:0]          piece_rot,
  output logic                new_piece,
  output logic                game_over,
  output logic                busy
);

  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);

  gen_state_e         state_q, state_d;
  logic               start_d;
  logic               req;
  logic [15:0]        lfsr_state;
  logic [2:0]         cand;
  logic [7:0]         used8;
  logic               cand_ok;
  logic               tries_done;
  logic               accept;
  logic [2:0]         fallback;
  logic [2:0]         pick;
  logic [6:0]         bag_set;
  spawn_mask_t        mask;
  logic               unused_lfsr_hi;

  logic [TriesW-1:0]  tries_q, tries_d;
  logic [6:0]         bag_q, bag_d;
  logic [2:0]         type_q, type_d;
  logic [BOARD_W-1:0] row0_q, row0_d;
  logic               collide_q, collide_d;
  logic               game_over_q, game_over_d;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clka      (clka),
    .restart_n (restart_n),
    .en        (state_q == StPick),
    .state     (lfsr_state)
  );

  assign unused_lfsr_hi = ^lfsr_state[15:3];
  assign req            = start_gen & ~start_d;
  assign cand           = lfsr_state[2:0];
  // Candidate 7 is never a valid type, so treat it as permanently used.
  assign used8          = {1'b1, bag_q};
  assign cand_ok        = ~used8[cand];
  assign tries_done     = (tries_q == TriesW'(MAX_TRIES));
  assign accept         = (state_q == StPick) && (cand_ok || tries_done);
  assign pick           = tries_done ? fallback : cand;
  assign bag_set        = bag_q | (7'd1 << pick);
  assign mask           = spawn_mask(type_q, 4'(SPAWN_X));

  always_comb begin
    fallback = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (!bag_q[i]) fallback = 3'(i);
    end
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= StIdle;
      start_d <= 1'b0;
    end else begin
      state_q <= state_d;
      start_d <= start_gen;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req && !game_over_q) state_d = StPick;
      StPick:  if (accept) state_d = StRd0;
      StRd0:   state_d = StRd1;
      StRd1:   state_d = StCheck;
      StCheck: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (restart) state_d = StIdle;
  end

  always_comb begin
    tries_d     = tries_q;
    bag_d       = bag_q;
    type_d      = type_q;
    row0_d      = row0_q;
    collide_d   = collide_q;
    game_over_d = game_over_q;
    if (state_q == StIdle) tries_d = '0;
    if (state_q == StPick && !restart) begin
      if (accept) begin
        type_d = pick;
        bag_d  = (bag_set == 7'h7F) ? 7'h00 : bag_set;
      end else begin
        tries_d = tries_q + 1'b1;
      end
    end
    if (state_q == StRd1) row0_d = brd_rd_data;
    if (state_q == StCheck) begin
      collide_d = (|(row0_q & mask.m0)) | (|(brd_rd_data & mask.m1));
    end
    if (state_q == StDone) game_over_d = game_over_q | collide_q;
    if (restart) begin
      bag_d       = '0;
      game_over_d = 1'b0;
    end
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      tries_q     <= '0;
      bag_q       <= '0;
      type_q      <= '0;
      row0_q      <= '0;
      collide_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      tries_q     <= tries_d;
      bag_q       <= bag_d;
      type_q      <= type_d;
      row0_q      <= row0_d;
      collide_q   <= collide_d;
      game_over_q <= game_over_d;
    end
  end

  always_comb begin
    brd_rd_en   = (state_q == StRd0) || (state_q == StRd1);
    brd_rd_addr = (state_q == StRd1) ? 5'd1 : 5'd0;
    new_piece   = (state_q == StDone) && !restart;
    busy        = (state_q != StIdle);
    game_over   = game_over_q;
    piece_type  = type_q;
    piece_x     = 4'(SPAWN_X);
    piece_y     = 5'd0;
    piece_rot   = 2'd0;
  end

endmodule

// File: doc/piece_gen.md
Name: piece_gen

Overview:
- Generation stage directly downstream of the main game FSM; it services the GEN state.
- On each new generation request it draws the next tetromino from a 7-bag randomiser and places it at the spawn position.
- It reads the top two board rows to check for a spawn collision, then reports completion (new_piece) and any spawn collision (game_over) back to the FSM.

Parameters:
- LFSR_SEED, 16'hACE1, reset value of randomiser; must be non-zero.
- MAX_TRIES, 16, PICK cycles allowed before the deterministic fallback.
- SPAWN_X, 3, leftmost column of the spawn bounding box.

Ports:
- clka  in  1  single system clock, rising-edge.
- restart_n  in  1  asynchronous active-low reset.
- restart  in  1  synchronous game restart: clear bag and game_over, abort any operation.
- start_gen  in  1  level from FSM, high while in GEN; a request is its rising edge.
- brd_rd_en  out  1  board read strobe.
- brd_rd_addr  out  5  board row, 0 = top.
- brd_rd_data  in  10  row contents, valid 1 cycle after strobe; bit i = column i, column 0 leftmost.
- piece_type  out  3  I=0 O=1 T=2 S=3 Z=4 J=5 L=6.
- piece_x  out  4  spawn column, equals SPAWN_X.
- piece_y  out  5  spawn row, equals 0.
- piece_rot  out  2  spawn rotation, equals 0.
- new_piece  out  1  one-cycle done pulse.
- game_over  out  1  sticky spawn-collision flag.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (restart_n=0): state=IDLE, lfsr=LFSR_SEED, bag_used=0, start_d=0; all outputs 0 except piece_x=SPAWN_X.
- Request detection: start_gen & ~start_d, with start_d registered every cycle.
  - Accepted only in IDLE with game_over=0; otherwise ignored, never queued.
- States: IDLE -> PICK -> RD0 -> RD1 -> CHECK -> DONE -> IDLE.
- PICK:
  - Candidate c = lfsr[2:0]; the LFSR shifts every PICK cycle.
  - Shift rule: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Accept if c != 7 and bag_used[c] = 0.
  - Otherwise try again; after MAX_TRIES rejected cycles, take the lowest-index unused type.
  - On accept: latch piece_type and set bag_used[c].
  - If bag_used would become 7'h7F, it clears to 0 instead, which starts a new bag.
- RD0: brd_rd_en=1, brd_rd_addr=0.
- RD1: brd_rd_en=1, brd_rd_addr=1; capture row0.
- CHECK:
  - Capture row1 and build spawn masks m0/m1 (shifted by SPAWN_X-3):
  - I: m0=0, m1=cols 3-6.
  - O: m0=cols 4-5, m1=cols 4-5.
  - T: m0=col 4, m1=cols 3-5.
  - S: m0=cols 4-5, m1=cols 3-4.
  - Z: m0=cols 3-4, m1=cols 4-5.
  - J: m0=col 3, m1=cols 3-5.
  - L: m0=col 5, m1=cols 3-5.
  - collide = |(row0&m0) | |(row1&m1).
- DONE:
  - new_piece=1 for exactly one cycle.
  - game_over <= collide, and it stays set until restart or reset.
  - piece_* hold until the next accept.
- Latency: new_piece is high exactly 4 cycles after the accepting PICK cycle; minimum 5 cycles after the request edge.
- brd_rd_en is 0 outside RD0/RD1.
- restart: in any state, go to IDLE next cycle, clear bag_used and game_over, suppress new_piece; the LFSR keeps running state.
- restart and a start_gen edge in the same cycle: restart wins and the request is dropped.
- restart_n mid-operation: asynchronous return to the reset values above.

Decomposition:
- tetris_pkg holds:
  - piece-type constants;
  - BOARD_W=10, BOARD_H=20;
  - state encoding;
  - spawn-mask function (type, x) -> {m0,m1}, shared with the movement and land stages.
- One sub-module, lfsr16: enable, seed parameter, 16-bit state output.

Test Plan:
- Reset, empty board (all rows 0), start_gen pulse -> first accepted c=1: piece_type=1 (O), new_piece 1 cycle, game_over=0, brd_rd_addr sequence 0,1.
- Seven consecutive requests on an empty board -> piece_types form a permutation of 0..6; the eighth request starts a new bag (bag_used cleared).
- Board row1=10'b0000010000 (col 4 set), force type T via the fallback path -> game_over=1 after new_piece; a further start_gen edge is ignored (busy stays 0).
- start_gen held high for 20 cycles -> exactly one new_piece.
- restart asserted during RD1 -> IDLE next cycle, no new_piece, game_over=0, bag_used=0.
- Force bag_used=7'h7E and an LFSR sequence that never yields c=0 -> fallback picks type 0 on PICK cycle MAX_TRIES+1.
